uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 35 +++
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver-side, consumer-side and status signals of uart_rx_fifo.
// slave is the FIFO's view, master is the view of whatever drives it.
//
// Handshake: rxDone is a one-cycle strobe with rxByte valid in the same cycle
// (no back-pressure to the receiver). On the consumer side a byte transfers in
// every cycle where byteValid and byteReady are both 1; byteValid never depends
// on byteReady, and byteOut is stable while byteValid is held without byteReady.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                         rxStart;
    logic                         rxDone;
    logic [DATA_WIDTH-1:0]        rxByte;
    logic [DATA_WIDTH-1:0]        byteOut;
    logic                         byteValid;
    logic                         byteReady;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    logic                         overrun;
    logic                         clrOverrun;
    logic                         frameEnd;
    logic [1:0]                   timerState;  // idle-timer FSM state, debug only

    modport slave (
        input  rxStart, rxDone, rxByte, byteReady, clrOverrun,
        output byteOut, byteValid, count, full, empty, overrun, frameEnd, timerState
    );

    modport master (
        output rxStart, rxDone, rxByte, byteReady, clrOverrun,
        input  byteOut, byteValid, count, full, empty, overrun, frameEnd, timerState
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and its consumer, with a sticky overrun
// flag and an idle timer that pulses frameEnd once the line has been quiet for
// IDLE_TIMEOUT cycles after the last received byte.
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int IDLE_TIMEOUT = 10000
) (
    input  logic           clk,
    input  logic           rstN,   // synchronous, active-high despite the name
    uart_rx_fifo_if.slave  bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CNW = $clog2(DEPTH + 1);
    localparam int TW  = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // disarmed
        ST_RX   = 2'd1,  // byte in progress on the line
        ST_GAP  = 2'd2   // counting idle cycles after a byte
    } timer_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CNW-1:0]        count_q;
    logic                  overrun_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    timer_state_t          state;
    timer_state_t          state_next;
    logic [TW-1:0]         tcnt;
    logic [TW-1:0]         tcnt_next;
    logic                  frame_end_q;
    logic                  frame_end_next;

    assign full_w  = (count_q == CNW'(DEPTH));
    assign empty_w = (count_q == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    assign pop     = !empty_w && bus.byteReady;
    assign wr_en   = bus.rxDone && (!full_w || pop);
    assign drop    = bus.rxDone && full_w && !pop;

    assign bus.byteOut    = empty_w ? '0 : mem[rd_ptr];
    assign bus.byteValid  = !empty_w;
    assign bus.count      = count_q;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.overrun    = overrun_q;
    assign bus.frameEnd   = frame_end_q;
    assign bus.timerState = state;

    // Storage array: written on accepted bytes only, never reset.
    always_ff @(posedge clk) begin
        if (!rstN && wr_en) begin
            mem[wr_ptr] <= bus.rxByte;
        end
    end

    // Pointers, occupancy and the sticky overrun flag (a drop beats a clear).
    always_ff @(posedge clk) begin
        if (rstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clrOverrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Idle-timer state register; frameEnd is registered so it is a clean pulse.
    always_ff @(posedge clk) begin
        if (rstN) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state       <= state_next;
            tcnt        <= tcnt_next;
            frame_end_q <= frame_end_next;
        end
    end

    // Idle-timer next state. Line activity (start or done) always takes priority
    // over the timeout; a start seen together with a done counts as a new byte
    // beginning. Dropped bytes still raise rxDone and so restart the gap.
    always_comb begin
        state_next     = state;
        tcnt_next      = tcnt;
        frame_end_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rxStart) begin
                    state_next = ST_RX;
                end else if (bus.rxDone) begin
                    state_next = ST_GAP;
                    tcnt_next  = '0;
                end
            end
            ST_RX: begin
                if (bus.rxStart) begin
                    state_next = ST_RX;
                end else if (bus.rxDone) begin
                    state_next = ST_GAP;
                    tcnt_next  = '0;
                end
            end
            ST_GAP: begin
                if (bus.rxStart) begin
                    state_next = ST_RX;
                    tcnt_next  = '0;
                end else if (bus.rxDone) begin
                    tcnt_next  = '0;
                end else if (tcnt == TW'(IDLE_TIMEOUT - 1)) begin
                    state_next     = ST_IDLE;
                    tcnt_next      = '0;
                    frame_end_next = 1'b1;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tcnt_next  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based model of the FIFO and an event-time
// model of the idle timer, compared against the DUT on every falling edge,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int IDLE_T = 20;

    logic clk;
    logic rstN;
    uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .IDLE_TIMEOUT(IDLE_T)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_q[$];
    bit exp_ovr = 0;
    bit exp_fe = 0;
    int edge_n = 0;
    int last_done = 0;
    bit armed = 0;

    // frameEnd is due exactly IDLE_T edges after the last rxDone, provided no
    // start, later done or reset intervened.
    always @(posedge clk) begin
        bit do_pop;
        bit was_full;
        edge_n++;
        if (rstN) begin
            exp_q.delete();
            exp_ovr = 0;
            armed = 0;
            exp_fe = 0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            do_pop = (exp_q.size() != 0) && bus.byteReady;
            if (do_pop) void'(exp_q.pop_front());
            if (bus.rxDone) begin
                if (!was_full || do_pop) exp_q.push_back(bus.rxByte);
            end
            if (bus.rxDone && was_full && !do_pop) exp_ovr = 1;
            else if (bus.clrOverrun) exp_ovr = 0;
            if (bus.rxStart) begin
                armed = 0;
            end else if (bus.rxDone) begin
                armed = 1;
                last_done = edge_n;
            end
            exp_fe = armed && (edge_n - last_done == IDLE_T);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("byteValid", 32'(bus.byteValid), 32'(exp_q.size() != 0));
            check("byteOut", 32'(bus.byteOut), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
            check("count", 32'(bus.count), 32'(exp_q.size()));
            check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
            check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
            check("overrun", 32'(bus.overrun), 32'(exp_ovr));
            check("frameEnd", 32'(bus.frameEnd), 32'(exp_fe));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.rxStart    = 1'b0;
        bus.rxDone     = 1'b0;
        bus.clrOverrun = 1'b0;
        bus.byteReady  = 1'b0;
        rstN           = 1'b0;
    endtask

    task automatic do_reset();
        rstN = 1'b1;
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [DW-1:0] b, input bit with_start);
        if (with_start) begin
            bus.rxStart = 1'b1;
            tick();
        end
        bus.rxByte = b;
        bus.rxDone = 1'b1;
        tick();
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) push_byte(base + DW'(i), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int pulse_k;
        int done_pct[5];
        int ready_pct[5];
        logic [DW-1:0] v;

        bus.rxStart = 0; bus.rxDone = 0; bus.rxByte = '0;
        bus.byteReady = 0; bus.clrOverrun = 0; rstN = 1'b1;

        // Reset state
        do_reset();
        checking = 1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_valid", 32'(bus.byteValid), 32'd0);
        check("rst_byteOut", 32'(bus.byteOut), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_frameEnd", 32'(bus.frameEnd), 32'd0);

        // Single byte, show-ahead latency
        push_byte(8'hA5, 1'b0);
        check("first_valid", 32'(bus.byteValid), 32'd1);
        check("first_byteOut", 32'(bus.byteOut), 32'hA5);
        check("first_count", 32'(bus.count), 32'd1);
        check("first_empty", 32'(bus.empty), 32'd0);
        bus.byteReady = 1'b1;
        tick();
        check("pop_empty", 32'(bus.empty), 32'd1);
        bus.byteReady = 1'b1;  // pop while empty does nothing
        tick();
        check("pop_when_empty_count", 32'(bus.count), 32'd0);

        // Overfill: 0x10 dropped
        do_reset();
        fill(8'h00);
        push_byte(8'h10, 1'b0);
        check("ovf_full", 32'(bus.full), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        check("ovf_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_order", 32'(bus.byteOut), 32'(i));
            bus.byteReady = 1'b1;
            tick();
        end
        check("ovf_drained", 32'(bus.byteValid), 32'd0);

        // Full FIFO, write with simultaneous pop
        do_reset();
        fill(8'h20);
        bus.rxByte = 8'h77; bus.rxDone = 1'b1; bus.byteReady = 1'b1;
        tick();
        check("wp_count", 32'(bus.count), 32'd16);
        check("wp_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check("wp_order", 32'(bus.byteOut), 32'h20 + 32'(i));
            bus.byteReady = 1'b1;
            tick();
        end
        check("wp_last", 32'(bus.byteOut), 32'h77);

        // Drop and clear in the same cycle: set wins
        do_reset();
        fill(8'h40);
        bus.rxByte = 8'h99; bus.rxDone = 1'b1; bus.clrOverrun = 1'b1;
        tick();
        check("setwins_overrun", 32'(bus.overrun), 32'd1);
        bus.clrOverrun = 1'b1;
        tick();
        check("clr_overrun", 32'(bus.overrun), 32'd0);

        // Idle timeout: one pulse 20 edges after rxDone
        do_reset();
        bus.rxStart = 1'b1;
        tick();
        tick();
        tick();
        push_byte(8'h11, 1'b0);
        pulses = 0; pulse_k = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.frameEnd) begin pulses++; pulse_k = k; end
        end
        check("fe_pulses", 32'(pulses), 32'd1);
        check("fe_time", 32'(pulse_k), 32'd20);

        // Second rxDone at gap cycle 15 postpones the pulse
        push_byte(8'h12, 1'b0);
        pulses = 0; pulse_k = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 15) begin
                bus.rxByte = 8'h13;
                bus.rxDone = 1'b1;
            end
            tick();
            if (bus.frameEnd) begin pulses++; pulse_k = k; end
        end
        check("fe2_pulses", 32'(pulses), 32'd1);
        check("fe2_time", 32'(pulse_k), 32'd35);

        // Reset mid-gap discards bytes and the pending pulse
        do_reset();
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        repeat (5) tick();
        check("pre_rst_count", 32'(bus.count), 32'd3);
        rstN = 1'b1;
        tick();
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_valid", 32'(bus.byteValid), 32'd0);
        check("midrst_byteOut", 32'(bus.byteOut), 32'd0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.frameEnd) pulses++;
        end
        check("midrst_no_fe", 32'(pulses), 32'd0);

        // Randomized phases with varied write and read pressure
        done_pct  = '{30, 60, 90, 4, 40};
        ready_pct = '{50, 10, 30, 70, 0};
        for (int ph = 0; ph < 5; ph++) begin
            for (int c = 0; c < 600; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < done_pct[ph]) begin
                    v = DW'($urandom_range(0, 255));
                    bus.rxByte = v;
                    bus.rxDone = 1'b1;
                end else if (r < done_pct[ph] + 4) begin
                    bus.rxStart = 1'b1;
                end
                bus.byteReady  = ($urandom_range(0, 99) < ready_pct[ph]);
                bus.clrOverrun = ($urandom_range(0, 99) < 3);
                rstN           = ($urandom_range(0, 999) < 2);
                tick();
                if (ph == 3 && $urandom_range(0, 99) < 5) repeat (25) tick();
            end
        end
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
